// File: rtl/des_key_schedule_dec.sv
// Sequential DES key schedule, decrypt order (K16 first, K1 last), one subkey per handshake.
// Optional macro DES_KS_ENC_EN adds an encrypt input selecting K1..K16 order with left rotations.
module des_key_schedule_dec (
  input  logic        clk,
  input  logic        rst,
`ifdef DES_KS_ENC_EN
  input  logic        encrypt,
`endif
  input  logic        key_valid,
  output logic        key_ready,
  input  logic [63:0] key,
  output logic        subkey_valid,
  input  logic        subkey_ready,
  output logic [47:0] subkey,
  output logic [3:0]  subkey_idx,
  output logic        subkey_last
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam int PC1 [56] = '{57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
                              10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
                              63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
                              14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
  localparam int PC2 [48] = '{14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
                              23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
                              41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
                              44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  // Bit n of the DES numbering (1 = MSB) lives at vector index width-n.
  function automatic logic [55:0] pc1_f(input logic [63:0] k);
    logic [55:0] r;
    r = '0;
    for (int i = 0; i < 56; i++) r[55-i] = k[64-PC1[i]];
    return r;
  endfunction

  function automatic logic [47:0] pc2_f(input logic [55:0] cd);
    logic [47:0] r;
    r = '0;
    for (int i = 0; i < 48; i++) r[47-i] = cd[56-PC2[i]];
    return r;
  endfunction

  // Rounds 1, 2, 9 and 16 (indices 0, 1, 8, 15) shift by one; all others by two.
  function automatic logic shift_one_f(input logic [3:0] i);
    return (i == 4'd0) || (i == 4'd1) || (i == 4'd8) || (i == 4'd15);
  endfunction

  function automatic logic [27:0] rotr_f(input logic [27:0] x, input logic two);
    return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
  endfunction

`ifdef DES_KS_ENC_EN
  function automatic logic [27:0] rotl_f(input logic [27:0] x, input logic two);
    return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
  endfunction
`endif

  state_t      state, state_nxt;
  logic [27:0] c, d, c_nxt, d_nxt;
  logic [3:0]  idx, idx_nxt;
`ifdef DES_KS_ENC_EN
  logic        enc, enc_nxt;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      c     <= '0;
      d     <= '0;
      idx   <= '0;
`ifdef DES_KS_ENC_EN
      enc   <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      c     <= c_nxt;
      d     <= d_nxt;
      idx   <= idx_nxt;
`ifdef DES_KS_ENC_EN
      enc   <= enc_nxt;
`endif
    end
  end

  // Decrypt starts from unrotated C0/D0: the 16 left shifts total 28, so C16 == C0.
  always_comb begin
    state_nxt = state;
    c_nxt     = c;
    d_nxt     = d;
    idx_nxt   = idx;
`ifdef DES_KS_ENC_EN
    enc_nxt   = enc;
`endif
    case (state)
      IDLE: begin
        if (key_valid) begin
          {c_nxt, d_nxt} = pc1_f(key);
          idx_nxt        = 4'd15;
          state_nxt      = RUN;
`ifdef DES_KS_ENC_EN
          enc_nxt = encrypt;
          if (encrypt) begin
            c_nxt   = rotl_f(c_nxt, 1'b0);
            d_nxt   = rotl_f(d_nxt, 1'b0);
            idx_nxt = 4'd0;
          end
`endif
        end
      end
      RUN: begin
        if (subkey_ready) begin
`ifdef DES_KS_ENC_EN
          if (enc) begin
            if (idx == 4'd15) begin
              state_nxt = IDLE;
            end else begin
              idx_nxt = idx + 4'd1;
              c_nxt   = rotl_f(c, !shift_one_f(idx + 4'd1));
              d_nxt   = rotl_f(d, !shift_one_f(idx + 4'd1));
            end
          end else
`endif
          if (idx == 4'd0) begin
            state_nxt = IDLE;
          end else begin
            idx_nxt = idx - 4'd1;
            c_nxt   = rotr_f(c, !shift_one_f(idx));
            d_nxt   = rotr_f(d, !shift_one_f(idx));
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign key_ready    = (state == IDLE);
  assign subkey_valid = (state == RUN);
  assign subkey       = subkey_valid ? pc2_f({c, d}) : 48'h0;
  assign subkey_idx   = idx;
`ifdef DES_KS_ENC_EN
  assign subkey_last  = subkey_valid && (enc ? (idx == 4'd15) : (idx == 4'd0));
`else
  assign subkey_last  = subkey_valid && (idx == 4'd0);
`endif

endmodule

// File: tb/tb_des_key_schedule_dec.sv
// Testbench for des_key_schedule_dec: directed and random keys against a bit-array DES schedule model.
module tb_des_key_schedule_dec;

  logic        clk = 1'b0;
  logic        rst;
  logic        key_valid;
  logic        key_ready;
  logic [63:0] key;
  logic        subkey_valid;
  logic        subkey_ready;
  logic [47:0] subkey;
  logic [3:0]  subkey_idx;
  logic        subkey_last;
`ifdef DES_KS_ENC_EN
  logic        encrypt;
`endif

  int tests = 0;
  int fails = 0;

  localparam logic [63:0] GOLD   = 64'h133457799BBCDFF1;
  localparam logic [63:0] PARITY = 64'h0101010101010101;

  localparam int PC1_T [56] = '{57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
                                10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
                                63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
                                14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
  localparam int PC2_T [48] = '{14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
                                23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
                                41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
                                44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  localparam int SH_T [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  logic [47:0] ks [16];

  des_key_schedule_dec dut (
    .clk          (clk),
    .rst          (rst),
`ifdef DES_KS_ENC_EN
    .encrypt      (encrypt),
`endif
    .key_valid    (key_valid),
    .key_ready    (key_ready),
    .key          (key),
    .subkey_valid (subkey_valid),
    .subkey_ready (subkey_ready),
    .subkey       (subkey),
    .subkey_idx   (subkey_idx),
    .subkey_last  (subkey_last)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Standard encrypt-order schedule: ks[r] is K(r+1); bit arrays indexed from DES bit 1.
  task automatic model(input logic [63:0] k);
    bit c[28], d[28], t[28], u[28];
    int p;
    for (int i = 0; i < 28; i++) begin
      c[i] = k[64-PC1_T[i]];
      d[i] = k[64-PC1_T[i+28]];
    end
    for (int r = 0; r < 16; r++) begin
      for (int s = 0; s < SH_T[r]; s++) begin
        for (int i = 0; i < 28; i++) begin
          t[i] = c[(i+1)%28];
          u[i] = d[(i+1)%28];
        end
        c = t;
        d = u;
      end
      for (int j = 0; j < 48; j++) begin
        p = PC2_T[j];
        ks[r][47-j] = (p <= 28) ? c[p-1] : d[p-29];
      end
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accept a key, then walk the 16 decrypt subkeys, optionally stalling 5 cycles at bp_idx.
  task automatic run_dec(input logic [63:0] k, input int bp_idx, input string tag);
    int e;
    model(k);
    key       = k;
    key_valid = 1'b1;
    chk({tag, "_ready_idle"}, 64'(key_ready), 64'd1);
    step();
    key_valid = 1'b0;
    for (int n = 0; n < 16; n++) begin
      e = 15 - n;
      chk({tag, "_valid"}, 64'(subkey_valid), 64'd1);
      chk({tag, "_idx"}, 64'(subkey_idx), 64'(e));
      chk({tag, "_subkey"}, 64'(subkey), 64'(ks[e]));
      chk({tag, "_last"}, 64'(subkey_last), 64'(e == 0));
      if (e == bp_idx) begin
        subkey_ready = 1'b0;
        for (int b = 0; b < 5; b++) begin
          step();
          chk({tag, "_bp_subkey"}, 64'(subkey), 64'(ks[e]));
          chk({tag, "_bp_idx"}, 64'(subkey_idx), 64'(e));
          chk({tag, "_bp_last"}, 64'(subkey_last), 64'(e == 0));
        end
        subkey_ready = 1'b1;
      end
      step();
    end
    chk({tag, "_ready_after"}, 64'(key_ready), 64'd1);
    chk({tag, "_valid_after"}, 64'(subkey_valid), 64'd0);
  endtask

  initial begin
    rst          = 1'b1;
    key_valid    = 1'b0;
    key          = 64'h0;
    subkey_ready = 1'b1;
`ifdef DES_KS_ENC_EN
    encrypt      = 1'b0;
`endif
    step();
    step();
    chk("rst_key_ready", 64'(key_ready), 64'd1);
    chk("rst_valid", 64'(subkey_valid), 64'd0);
    chk("rst_subkey", 64'(subkey), 64'd0);
    chk("rst_idx", 64'(subkey_idx), 64'd0);
    chk("rst_last", 64'(subkey_last), 64'd0);
    rst = 1'b0;

    model(GOLD);
    chk("model_k1", 64'(ks[0]), 64'h1B02EFFC7072);
    chk("model_k16", 64'(ks[15]), 64'hCB3D8B0E17F5);

    run_dec(GOLD, -1, "dec");
    run_dec(GOLD, 10, "bp");
    run_dec(GOLD ^ PARITY, -1, "parity");
    repeat (4) run_dec({$urandom, $urandom}, int'($urandom_range(0, 15)), "rnd");

    // Busy key offered from idx 8, then reset while idx 5 is on the output.
    model(GOLD);
    key       = GOLD;
    key_valid = 1'b1;
    step();
    key_valid = 1'b0;
    for (int i = 15; i >= 5; i--) begin
      chk("mid_idx", 64'(subkey_idx), 64'(i));
      chk("mid_subkey", 64'(subkey), 64'(ks[i]));
      if (i <= 8) begin
        key       = ~GOLD;
        key_valid = 1'b1;
        chk("mid_busy_ready", 64'(key_ready), 64'd0);
      end
      if (i != 5) step();
    end
    rst = 1'b1;
    step();
    rst       = 1'b0;
    key_valid = 1'b0;
    chk("mid_rst_valid", 64'(subkey_valid), 64'd0);
    chk("mid_rst_ready", 64'(key_ready), 64'd1);
    chk("mid_rst_subkey", 64'(subkey), 64'd0);
    chk("mid_rst_idx", 64'(subkey_idx), 64'd0);
    chk("mid_rst_last", 64'(subkey_last), 64'd0);

    run_dec(64'h0, -1, "zero");

`ifdef DES_KS_ENC_EN
    model(GOLD);
    encrypt   = 1'b1;
    key       = GOLD;
    key_valid = 1'b1;
    step();
    key_valid = 1'b0;
    encrypt   = 1'b0;
    for (int n = 0; n < 16; n++) begin
      chk("enc_idx", 64'(subkey_idx), 64'(n));
      chk("enc_subkey", 64'(subkey), 64'(ks[n]));
      chk("enc_last", 64'(subkey_last), 64'(n == 15));
      step();
    end
    chk("enc_ready_after", 64'(key_ready), 64'd1);
    run_dec(GOLD, 3, "dec_after_enc");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
